pin_entry_controller: RTL and testbench

- Keypad-side sequencer for the door lock FSM.
- Collects a fixed-length PIN from debounced key strobes and compares it against the stored PIN.
- On a match it issues a one-cycle toggle pulse to the lock FSM. On a mismatch it counts the failure.
- After MAX_FAILS consecutive failures it blocks the keypad for a fixed period and asserts override, which the lock FSM uses to ignore keypad toggles.

---
 rtl/pin_entry_controller_if.sv | 21 ++
 rtl/pin_entry_controller.sv | 175 +++++++++++++++++
 tb/tb_pin_entry_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pin_entry_controller_if.sv
// Keypad strobe and status bundle between the keypad front end (master) and
// pin_entry_controller (slave).
interface pin_entry_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       toggle_lock;
    logic       fail_pulse;
    logic       override;
    logic [2:0] digit_count;
    logic [2:0] fail_count;

    modport master (
        output key_valid, key_code,
        input  toggle_lock, fail_pulse, override, digit_count, fail_count
    );

    modport slave (
        input  key_valid, key_code,
        output toggle_lock, fail_pulse, override, digit_count, fail_count
    );
endinterface

// File: rtl/pin_entry_controller.sv
// PIN collection, compare and lockout sequencer in front of the door lock FSM.
// Define INTER_KEY_TIMEOUT_EN to abandon a partial entry after KEY_TIMEOUT idle cycles.
module pin_entry_controller #(
    parameter int                      PIN_DIGITS   = 4,
    parameter logic [PIN_DIGITS*4-1:0] PIN_VALUE    = 16'h1234,
    parameter int                      MAX_FAILS    = 3,
    parameter int                      BLOCK_CYCLES = 150,
    parameter int                      KEY_TIMEOUT  = 25
) (
    input logic                   clk5,
    input logic                   reset,
    pin_entry_controller_if.slave bus
);
    localparam int ENTRY_W = PIN_DIGITS * 4;
    localparam int BLK_W   = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;

    localparam logic [2:0]       DIGITS_LAST = 3'(PIN_DIGITS);
    localparam logic [2:0]       FAILS_LIMIT = 3'(MAX_FAILS);
    localparam logic [BLK_W-1:0] BLOCK_LOAD  = BLK_W'(BLOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        CHECK,
        BLOCKED
    } state_t;

    state_t             state, state_next;
    logic [ENTRY_W-1:0] entry, entry_next;
    logic [2:0]         digits, digits_next;
    logic [2:0]         fails, fails_next;
    logic [BLK_W-1:0]   block_cnt, block_next;
    logic               toggle_q, toggle_next;
    logic               fail_q, fail_next;
    logic               override_q, override_next;

    logic               digit_key;
    logic               clear_key;
    logic [ENTRY_W-1:0] entry_shifted;

`ifdef INTER_KEY_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(KEY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(KEY_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(1);

    logic [TMO_W-1:0] idle_cnt, idle_next;
`endif

    assign digit_key     = bus.key_valid && (bus.key_code <= 4'h9);
    assign clear_key     = bus.key_valid && (bus.key_code == 4'hA);
    assign entry_shifted = (entry << 4) | ENTRY_W'(bus.key_code);

    always_comb begin
        state_next    = state;
        entry_next    = entry;
        digits_next   = digits;
        fails_next    = fails;
        block_next    = block_cnt;
        toggle_next   = 1'b0;
        fail_next     = 1'b0;
        override_next = 1'b0;
`ifdef INTER_KEY_TIMEOUT_EN
        idle_next     = idle_cnt;
`endif

        case (state)
            IDLE: begin
                digits_next = 3'd0;
                if (digit_key) begin
                    entry_next  = entry_shifted;
                    digits_next = 3'd1;
                    state_next  = (PIN_DIGITS == 1) ? CHECK : ENTRY;
`ifdef INTER_KEY_TIMEOUT_EN
                    idle_next   = TMO_LOAD;
`endif
                end
            end

            ENTRY: begin
                if (digit_key) begin
                    entry_next  = entry_shifted;
                    digits_next = digits + 3'd1;
                    if (digits + 3'd1 == DIGITS_LAST) begin
                        state_next = CHECK;
                    end
`ifdef INTER_KEY_TIMEOUT_EN
                    idle_next = TMO_LOAD;
`endif
                end else if (clear_key) begin
                    digits_next = 3'd0;
                    state_next  = IDLE;
`ifdef INTER_KEY_TIMEOUT_EN
                end else if (idle_cnt <= TMO_LAST) begin
                    // Abandoned entry: silently discard, no failure is recorded.
                    idle_next   = '0;
                    digits_next = 3'd0;
                    state_next  = IDLE;
                end else begin
                    idle_next = idle_cnt - TMO_LAST;
`endif
                end
            end

            CHECK: begin
                digits_next = 3'd0;
                if (entry == PIN_VALUE) begin
                    toggle_next = 1'b1;
                    fails_next  = 3'd0;
                    state_next  = IDLE;
                end else begin
                    fail_next  = 1'b1;
                    fails_next = fails + 3'd1;
                    if (fails + 3'd1 == FAILS_LIMIT) begin
                        block_next    = BLOCK_LOAD;
                        override_next = 1'b1;
                        state_next    = BLOCKED;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            BLOCKED: begin
                // Counter was loaded with BLOCK_CYCLES-1, so the exit edge lands
                // after exactly BLOCK_CYCLES cycles of override.
                if (block_cnt == '0) begin
                    fails_next = 3'd0;
                    state_next = IDLE;
                end else begin
                    block_next    = block_cnt - 1'b1;
                    override_next = 1'b1;
                end
            end

            default: begin
                state_next  = IDLE;
                digits_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk5) begin
        if (reset) begin
            state      <= IDLE;
            entry      <= '0;
            digits     <= 3'd0;
            fails      <= 3'd0;
            block_cnt  <= '0;
            toggle_q   <= 1'b0;
            fail_q     <= 1'b0;
            override_q <= 1'b0;
`ifdef INTER_KEY_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            state      <= state_next;
            entry      <= entry_next;
            digits     <= digits_next;
            fails      <= fails_next;
            block_cnt  <= block_next;
            toggle_q   <= toggle_next;
            fail_q     <= fail_next;
            override_q <= override_next;
`ifdef INTER_KEY_TIMEOUT_EN
            idle_cnt   <= idle_next;
`endif
        end
    end

    assign bus.toggle_lock = toggle_q;
    assign bus.fail_pulse  = fail_q;
    assign bus.override    = override_q;
    assign bus.digit_count = digits;
    assign bus.fail_count  = fails;
endmodule

// File: tb/tb_pin_entry_controller.sv
// Self-checking bench for pin_entry_controller: directed scenarios with literal
// expectations plus randomized keys checked every cycle against a behavioural model.
module tb_pin_entry_controller;
    localparam int          PIN_DIGITS   = 4;
    localparam logic [15:0] PIN_VALUE    = 16'h1234;
    localparam int          MAX_FAILS    = 3;
    localparam int          BLOCK_CYCLES = 150;
    localparam int          KEY_TIMEOUT  = 25;

    logic clk5 = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    pin_entry_controller_if bus();

    pin_entry_controller #(
        .PIN_DIGITS  (PIN_DIGITS),
        .PIN_VALUE   (PIN_VALUE),
        .MAX_FAILS   (MAX_FAILS),
        .BLOCK_CYCLES(BLOCK_CYCLES),
        .KEY_TIMEOUT (KEY_TIMEOUT)
    ) dut (
        .clk5 (clk5),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #100 clk5 = ~clk5;

    // Behavioural model: the entry is a queue of digits, the lockout a countdown of
    // remaining override cycles, pulses are recomputed every edge.
    int  m_digits[$];
    bit  m_checking  = 1'b0;
    int  m_block_left = 0;
    int  m_fails     = 0;
    bit  m_tog       = 1'b0;
    bit  m_fail      = 1'b0;
    int  m_idle_left = 0;
    bit  model_ready = 1'b0;

    task automatic model_step(input logic rst, input logic kv, input logic [3:0] kc);
        longint value;
        if (rst === 1'b1) begin
            m_digits.delete();
            m_checking   = 1'b0;
            m_block_left = 0;
            m_fails      = 0;
            m_tog        = 1'b0;
            m_fail       = 1'b0;
            m_idle_left  = 0;
            model_ready  = 1'b1;
        end else begin
            m_tog  = 1'b0;
            m_fail = 1'b0;
            if (m_checking) begin
                value = 0;
                foreach (m_digits[i]) value = value * 16 + m_digits[i];
                m_checking = 1'b0;
                m_digits.delete();
                if (value == longint'(PIN_VALUE)) begin
                    m_tog   = 1'b1;
                    m_fails = 0;
                end else begin
                    m_fail  = 1'b1;
                    m_fails = m_fails + 1;
                    if (m_fails == MAX_FAILS) m_block_left = BLOCK_CYCLES;
                end
            end else if (m_block_left > 0) begin
                m_block_left = m_block_left - 1;
                if (m_block_left == 0) m_fails = 0;
            end else if (kv === 1'b1 && kc <= 4'h9) begin
                m_digits.push_back(int'(kc));
                m_idle_left = KEY_TIMEOUT;
                if (m_digits.size() == PIN_DIGITS) m_checking = 1'b1;
            end else if (kv === 1'b1 && kc == 4'hA) begin
                m_digits.delete();
`ifdef INTER_KEY_TIMEOUT_EN
            end else if (m_digits.size() > 0) begin
                m_idle_left = m_idle_left - 1;
                if (m_idle_left == 0) m_digits.delete();
`endif
            end
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk5);
            model_step(reset, bus.key_valid, bus.key_code);
        end
    end

    initial begin
        forever begin
            @(negedge clk5);
            if (model_ready) begin
                check_output("model_toggle_lock", 32'(bus.toggle_lock), 32'(m_tog));
                check_output("model_fail_pulse",  32'(bus.fail_pulse),  32'(m_fail));
                check_output("model_override",    32'(bus.override),    32'(m_block_left > 0));
                check_output("model_digit_count", 32'(bus.digit_count), 32'(m_digits.size()));
                check_output("model_fail_count",  32'(bus.fail_count),  32'(m_fails));
            end
        end
    end

    // One call = one clock cycle of input; on return the outputs reflect the
    // edge that sampled the previous call's inputs.
    task automatic apply_stimulus(input logic rst, input logic kv, input logic [3:0] kc);
        @(negedge clk5);
        reset         = rst;
        bus.key_valid = kv;
        bus.key_code  = kc;
    endtask

    task automatic press(input logic [3:0] kc);
        apply_stimulus(1'b0, 1'b1, kc);
        apply_stimulus(1'b0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        apply_stimulus(1'b1, 1'b0, 4'h0);
        apply_stimulus(1'b0, 1'b0, 4'h0);
    endtask

    task automatic enter_pin(input logic [15:0] pin, input logic lits, input logic exp_tog,
                             input logic exp_fail, input logic [2:0] exp_fc);
        for (int i = 0; i < 4; i++) press(pin[15-4*i -: 4]);
        if (lits) check_output("check_digit_count", 32'(bus.digit_count), 32'd4);
        apply_stimulus(1'b0, 1'b0, 4'h0);
        if (lits) begin
            check_output("pulse_toggle_lock", 32'(bus.toggle_lock), 32'(exp_tog));
            check_output("pulse_fail_pulse",  32'(bus.fail_pulse),  32'(exp_fail));
            check_output("pulse_fail_count",  32'(bus.fail_count),  32'(exp_fc));
        end
    endtask

    initial begin
        int          ov_cycles;
        bit          saw_toggle;
        logic [3:0]  seq_keys [7];
        logic [2:0]  seq_dc   [7];
        int          r;
        logic [3:0]  kc;

        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;

        do_reset();
        check_output("reset_toggle_lock", 32'(bus.toggle_lock), 32'd0);
        check_output("reset_fail_pulse",  32'(bus.fail_pulse),  32'd0);
        check_output("reset_override",    32'(bus.override),    32'd0);
        check_output("reset_digit_count", 32'(bus.digit_count), 32'd0);
        check_output("reset_fail_count",  32'(bus.fail_count),  32'd0);

        press(4'hC);
        check_output("ignored_code_dc", 32'(bus.digit_count), 32'd0);

        enter_pin(16'h1234, 1'b1, 1'b1, 1'b0, 3'd0);
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("toggle_one_cycle", 32'(bus.toggle_lock), 32'd0);

        enter_pin(16'h1235, 1'b1, 1'b0, 1'b1, 3'd1);
        enter_pin(16'h1235, 1'b1, 1'b0, 1'b1, 3'd2);
        enter_pin(16'h1235, 1'b1, 1'b0, 1'b1, 3'd3);
        check_output("block_override_rise", 32'(bus.override), 32'd1);
        ov_cycles  = 1;
        saw_toggle = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c < 8) apply_stimulus(1'b0, 1'b1, 4'((c % 4) + 1));
            else       apply_stimulus(1'b0, 1'b0, 4'h0);
            if (bus.toggle_lock === 1'b1) saw_toggle = 1'b1;
            if (bus.override !== 1'b1) break;
            ov_cycles = ov_cycles + 1;
        end
        check_output("block_override_len", 32'(ov_cycles), 32'(BLOCK_CYCLES));
        check_output("block_no_toggle", 32'(saw_toggle), 32'd0);
        check_output("block_exit_fail_count", 32'(bus.fail_count), 32'd0);
        enter_pin(16'h1234, 1'b1, 1'b1, 1'b0, 3'd0);

        seq_keys = '{4'h1, 4'h2, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4};
        seq_dc   = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 7; i++) begin
            press(seq_keys[i]);
            check_output("clear_seq_dc", 32'(bus.digit_count), 32'(seq_dc[i]));
        end
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("clear_seq_toggle", 32'(bus.toggle_lock), 32'd1);
        check_output("clear_seq_fail",   32'(bus.fail_pulse),  32'd0);

        enter_pin(16'h1235, 1'b1, 1'b0, 1'b1, 3'd1);
        enter_pin(16'h9999, 1'b1, 1'b0, 1'b1, 3'd2);
        enter_pin(16'h1234, 1'b1, 1'b1, 1'b0, 3'd0);
        enter_pin(16'h1235, 1'b1, 1'b0, 1'b1, 3'd1);
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("single_fail_no_block", 32'(bus.override), 32'd0);

        do_reset();
        enter_pin(16'h1235, 1'b1, 1'b0, 1'b1, 3'd1);
        enter_pin(16'h1235, 1'b1, 1'b0, 1'b1, 3'd2);
        enter_pin(16'h1235, 1'b1, 1'b0, 1'b1, 3'd3);
        repeat (49) apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("block_cycle50_override", 32'(bus.override), 32'd1);
        do_reset();
        check_output("reset_in_block_override", 32'(bus.override),    32'd0);
        check_output("reset_in_block_fc",       32'(bus.fail_count),  32'd0);
        check_output("reset_in_block_dc",       32'(bus.digit_count), 32'd0);
        enter_pin(16'h1234, 1'b1, 1'b1, 1'b0, 3'd0);

        apply_stimulus(1'b0, 1'b1, 4'h1);
        apply_stimulus(1'b0, 1'b1, 4'h2);
        repeat (KEY_TIMEOUT + 1) apply_stimulus(1'b0, 1'b0, 4'h0);
`ifdef INTER_KEY_TIMEOUT_EN
        check_output("timeout_dc", 32'(bus.digit_count), 32'd0);
        press(4'h3);
        press(4'h4);
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("timeout_no_toggle", 32'(bus.toggle_lock), 32'd0);
        press(4'hA);
`else
        check_output("no_timeout_dc", 32'(bus.digit_count), 32'd2);
        press(4'h3);
        press(4'h4);
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("no_timeout_toggle", 32'(bus.toggle_lock), 32'd1);
`endif

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                enter_pin(PIN_VALUE, 1'b0, 1'b0, 1'b0, 3'd0);
            end else if (r < 7) begin
                repeat ($urandom_range(1, 5)) begin
                    if ($urandom_range(0, 3) == 0) kc = 4'($urandom_range(0, 15));
                    else                           kc = 4'($urandom_range(1, 5));
                    apply_stimulus(1'b0, $urandom_range(0, 3) != 0, kc);
                end
            end else if (r < 9) begin
                repeat ($urandom_range(1, 30)) apply_stimulus(1'b0, 1'b0, 4'h0);
            end else if ($urandom_range(0, 3) == 0) begin
                apply_stimulus(1'b1, 1'b0, 4'h0);
            end else begin
                apply_stimulus(1'b0, 1'b1, 4'hA);
            end
        end

        repeat (3) apply_stimulus(1'b0, 1'b0, 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk5) begin
        if (model_ready && bus.toggle_lock === 1'b1 && bus.fail_pulse === 1'b1)
            $error("[TB] toggle_lock and fail_pulse high together");
        if (model_ready && bus.toggle_lock === 1'b1 && bus.override === 1'b1)
            $error("[TB] toggle_lock high while override high");
    end
endmodule
